// File: rtl/ccff_chain_loader_if.sv
// Word stream into the configuration-chain loader.
//   word_in    : bitstream word
//   word_valid : word_in valid (source -> loader)
//   word_ready : loader accepts word_in this cycle (loader -> source)
// A transfer happens on a prog_clk edge with word_valid && word_ready.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
) ();
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_in, output word_valid, input word_ready);
  modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Configuration-chain feeder. Takes bitstream words from a valid/ready
// stream and shifts exactly CHAIN_LEN bits MSB-first onto ccff_head,
// qualifying each bit with chain_shift_en (gates prog_clk into the chain).
//
// Optional feature, macro CCFF_CHAIN_VERIFY_EN: after loading, the chain
// is recirculated once (ccff_head = ccff_tail for CHAIN_LEN cycles) and the
// parity of bits returned is compared with the parity of bits sent.
//
// Ports:
//   prog_clk, pReset  : clock (rising edge), async active-high reset
//   start             : pulse, begins a load from IDLE or DONE
//   wbus (slave)      : word_in / word_valid / word_ready
//   ccff_head         : serial bit to chain head
//   chain_shift_en    : chain captures ccff_head on the next edge
//   ccff_tail         : serial bit from chain tail
//   ccff_tail_out     : ccff_tail passed through for cascading
//   busy, done, error : status (done/error sticky until next start)
//   bit_count         : bits shifted in the current pass
module ccff_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 54,
  parameter int CNT_W     = 16
) (
  input  logic             prog_clk,
  input  logic             pReset,
  input  logic             start,
  ccff_chain_loader_if.slave wbus,
  output logic             ccff_head,
  output logic             chain_shift_en,
  input  logic             ccff_tail,
  output logic             ccff_tail_out,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] bit_count
);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
`ifdef CCFF_CHAIN_VERIFY_EN
    S_DONE  = 2'd2,
    S_VERIFY = 2'd3
`else
    S_DONE  = 2'd2
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] buf_q;
  logic [IDX_W-1:0]  idx_q;
  logic              buf_vld_q;
  logic [CNT_W-1:0]  loaded_q;   // bits committed into the buffer this pass
  logic [CNT_W-1:0]  cnt_q;
  logic              head_q, sh_q, done_q;

  logic shift_st, shift_fin, do_shift, accept, start_ok;

  assign shift_st  = (state_q == S_SHIFT);
  // cnt_q == LEN means the last bit is on ccff_head this cycle.
  assign shift_fin = shift_st && (cnt_q == LEN);
  assign do_shift  = shift_st && buf_vld_q && (cnt_q != LEN);
  // Stop requesting once every needed bit is buffered; leftovers are dropped.
  assign wbus.word_ready = shift_st && (loaded_q < LEN) &&
                           (!buf_vld_q || (idx_q == '0));
  assign accept    = wbus.word_valid && wbus.word_ready;
  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));

`ifdef CCFF_CHAIN_VERIFY_EN
  localparam logic [CNT_W-1:0] VLAST = CNT_W'(2 * CHAIN_LEN - 1);
  logic par_q;   // XOR of bits sent and bits returned; nonzero = mismatch
  logic err_q;
  logic ver_last;
  assign ver_last  = (state_q == S_VERIFY) && (cnt_q == VLAST);
  // Recirculate combinationally so the loop is exactly CHAIN_LEN flops.
  assign ccff_head = (state_q == S_VERIFY) ? ccff_tail : head_q;
  assign busy      = shift_st || (state_q == S_VERIFY);
  assign error     = err_q;
`else
  assign ccff_head = head_q;
  assign busy      = shift_st;
  assign error     = 1'b0;
`endif

  assign chain_shift_en = sh_q;
  assign ccff_tail_out  = ccff_tail;
  assign done           = done_q;
  assign bit_count      = cnt_q;

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_SHIFT;
`ifdef CCFF_CHAIN_VERIFY_EN
      S_SHIFT:  if (shift_fin) state_d = S_VERIFY;
      S_VERIFY: if (ver_last)  state_d = S_DONE;
`else
      S_SHIFT:  if (shift_fin) state_d = S_DONE;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      buf_q     <= '0;
      idx_q     <= '0;
      buf_vld_q <= 1'b0;
      loaded_q  <= '0;
      cnt_q     <= '0;
      head_q    <= 1'b0;
      sh_q      <= 1'b0;
      done_q    <= 1'b0;
`ifdef CCFF_CHAIN_VERIFY_EN
      par_q     <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else if (start_ok) begin
      buf_vld_q <= 1'b0;
      loaded_q  <= '0;
      cnt_q     <= '0;
      sh_q      <= 1'b0;
      done_q    <= 1'b0;
`ifdef CCFF_CHAIN_VERIFY_EN
      par_q     <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else if (shift_fin) begin
      buf_vld_q <= 1'b0;
`ifdef CCFF_CHAIN_VERIFY_EN
      sh_q      <= 1'b1;
`else
      sh_q      <= 1'b0;
      done_q    <= 1'b1;
`endif
    end else if (shift_st) begin
      sh_q <= do_shift;   // empty buffer: stall, head holds its value
      if (do_shift) begin
        head_q <= buf_q[idx_q];
        cnt_q  <= cnt_q + 1'b1;
        if (idx_q == '0) buf_vld_q <= 1'b0;
        else             idx_q     <= idx_q - 1'b1;
`ifdef CCFF_CHAIN_VERIFY_EN
        par_q  <= par_q ^ buf_q[idx_q];
`endif
      end
      // Accept overrides the empty flag so a word arriving on the last
      // bit of the previous one streams without a bubble.
      if (accept) begin
        buf_q     <= wbus.word_in;
        idx_q     <= IDX_TOP;
        buf_vld_q <= 1'b1;
        loaded_q  <= loaded_q + CNT_W'(WORD_W);
      end
    end
`ifdef CCFF_CHAIN_VERIFY_EN
    else if (state_q == S_VERIFY) begin
      cnt_q <= cnt_q + 1'b1;
      par_q <= par_q ^ ccff_tail;
      if (ver_last) begin
        sh_q   <= 1'b0;
        done_q <= 1'b1;
        err_q  <= par_q ^ ccff_tail;
      end
    end
`endif
  end
endmodule
